// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Summary  : Iterative RV32M multiply/divide unit (shift-add / restoring).
//            Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_op, w_op_nxt;
  logic [XLEN-1:0]   r_opnd, w_opnd_nxt;       // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] r_acc, w_acc_nxt;         // {hi, lo}: product or {remainder, quotient}
  logic              r_neg, w_neg_nxt;
  logic              r_neg_rem, w_neg_rem_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;

  logic              w_accept, w_is_div, w_sign1, w_sign2, w_div_zero, w_div_ovf;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_sub;
  logic [2*XLEN-1:0] w_mul_step, w_div_step;

  function automatic logic [XLEN-1:0] f_finish(
    input logic [2:0]        op,
    input logic              neg,
    input logic              neg_rem,
    input logic [2*XLEN-1:0] acc
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2]) return (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    return op[1] ? rem : quo;
  endfunction

  // Operand decode: signedness, sign bits restricted to signed operands, magnitudes.
  always_comb begin
    w_is_div   = funct3_i[2];
    w_sign1    = rs1_i[XLEN-1] & (w_is_div ? ~funct3_i[0] : (funct3_i[1:0] != 2'b11));
    w_sign2    = rs2_i[XLEN-1] & (w_is_div ? ~funct3_i[0] : ~funct3_i[1]);
    w_mag1     = w_sign1 ? -rs1_i : rs1_i;
    w_mag2     = w_sign2 ? -rs2_i : rs2_i;
    w_div_zero = w_is_div && (rs2_i == '0);
    w_div_ovf  = w_is_div && !funct3_i[0] && (rs1_i == C_INT_MIN) && (rs2_i == '1);
  end

  // One iteration of each algorithm. The restoring trial subtract cannot
  // exceed XLEN bits when it succeeds, so its MSB doubles as the borrow.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_step = {w_mul_sum, r_acc[XLEN-1:1]};
    w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_div_sub  = w_div_sh - {1'b0, r_opnd};
    w_div_step = {(w_div_sub[XLEN] ? w_div_sh[XLEN-1:0] : w_div_sub[XLEN-1:0]),
                  r_acc[XLEN-2:0], ~w_div_sub[XLEN]};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_a, w_fast_b, w_fast_prod;
  always_comb begin
    w_fast_a    = {{XLEN{w_sign1}}, rs1_i};
    w_fast_b    = {{XLEN{w_sign2}}, rs2_i};
    w_fast_prod = w_fast_a * w_fast_b;
  end
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_opnd_nxt    = r_opnd;
    w_acc_nxt     = r_acc;
    w_neg_nxt     = r_neg;
    w_neg_rem_nxt = r_neg_rem;
    w_cnt_nxt     = r_cnt;
    w_result_nxt  = r_result;
    w_accept      = start_i && !flush_i && (r_state == S_IDLE || r_state == S_DONE);

    case (r_state)
      S_MUL: begin
        w_acc_nxt = w_mul_step;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = f_finish(r_op, r_neg, r_neg_rem, w_mul_step);
        end
      end
      S_DIV: begin
        w_acc_nxt = w_div_step;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = S_DONE;
          w_result_nxt = f_finish(r_op, r_neg, r_neg_rem, w_div_step);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: ;
    endcase

    if (w_accept) begin
      w_op_nxt      = funct3_i;
      w_opnd_nxt    = w_is_div ? w_mag2 : w_mag1;
      w_acc_nxt     = {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
      w_neg_nxt     = w_sign1 ^ w_sign2;
      w_neg_rem_nxt = w_sign1;
      w_cnt_nxt     = CNT_W'(XLEN);
      if (w_div_zero) begin
        w_state_nxt  = S_DONE;
        w_result_nxt = funct3_i[1] ? rs1_i : '1;
      end else if (w_div_ovf) begin
        w_state_nxt  = S_DONE;
        w_result_nxt = funct3_i[1] ? '0 : rs1_i;
      end else if (w_is_div) begin
        w_state_nxt = S_DIV;
      end else begin
`ifdef MULDIV_FAST_MUL_EN
        w_state_nxt  = S_DONE;
        w_result_nxt = f_finish(funct3_i, 1'b0, 1'b0, w_fast_prod);
`else
        w_state_nxt = S_MUL;
`endif
      end
    end

    if (flush_i) begin
      w_state_nxt  = S_IDLE;
      w_result_nxt = r_result;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op      <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      r_op      <= w_op_nxt;
      r_opnd    <= w_opnd_nxt;
      r_acc     <= w_acc_nxt;
      r_neg     <= w_neg_nxt;
      r_neg_rem <= w_neg_rem_nxt;
      r_cnt     <= w_cnt_nxt;
      r_result  <= w_result_nxt;
    end
  end

  assign busy_o   = (r_state == S_MUL) || (r_state == S_DIV);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Summary  : Self-checking bench for muldiv_unit (default iterative build).
// Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  vec_t            vecs[$];
  logic [XLEN-1:0] exp_q[$];
  int              n_cmp = 0;
  int              n_err = 0;
  logic [XLEN-1:0] last_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one op at the current negedge; the next op may start in its done cycle.
  task automatic run_op(input int idx, input vec_t v);
    bit seen;
    bit busy_bad;
    start_i  = 1'b1;
    funct3_i = v.op;
    rs1_i    = v.a;
    rs2_i    = v.b;
    exp_q.push_back(v.exp);
    seen     = 1'b0;
    busy_bad = 1'b0;
    for (int c = 1; c <= 100 && !seen; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o === 1'b1) begin
        seen = 1'b1;
        check($sformatf("vec%0d_latency", idx), 64'(c), 64'(v.lat));
        check($sformatf("vec%0d_result", idx), 64'(result_o), 64'(exp_q.pop_front()));
        if (busy_o !== 1'b0) busy_bad = 1'b1;
      end else if (busy_o !== (v.lat > 1)) begin
        busy_bad = 1'b1;
      end
    end
    check($sformatf("vec%0d_done_seen", idx), 64'(seen), 64'd1);
    check($sformatf("vec%0d_busy_profile", idx), 64'(busy_bad), 64'd0);
    if (!seen && exp_q.size() > 0) void'(exp_q.pop_front());
  endtask

  initial begin
    int it = XLEN + 1;
    bit saw_done;
    bit saw_busy;

    vecs.push_back('{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, it});
    vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, it});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, it});
    vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, it});
    vecs.push_back('{3'b000, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0000_001E, it});
    vecs.push_back('{3'b000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, it});
    vecs.push_back('{3'b011, 32'h8000_0000, 32'h0000_0004, 32'h0000_0002, it});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, it});
    vecs.push_back('{3'b010, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, it});
    vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, it});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, it});
    vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        it});
    vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         it});
    vecs.push_back('{3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, it});
    vecs.push_back('{3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         it});
    vecs.push_back('{3'b101, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, it});
    vecs.push_back('{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b110, 32'd5,         32'd0,         32'd5,         1});
    vecs.push_back('{3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{3'b111, 32'd9,         32'd0,         32'd9,         1});
    vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{3'b111, 32'd1000,      32'd33,        32'd10,        it});

    rst_i    = 1'b1;
    start_i  = 1'b0;
    flush_i  = 1'b0;
    funct3_i = 3'b000;
    rs1_i    = '0;
    rs2_i    = '0;
    repeat (2) @(negedge clk_i);
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_result", 64'(result_o), 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table ops run back to back: each start lands in the previous done cycle.
    foreach (vecs[i]) run_op(i, vecs[i]);
    last_exp = vecs[vecs.size()-1].exp;

    repeat (3) @(negedge clk_i);
    check("result_held", 64'(result_o), 64'(last_exp));

    // Flush in cycle 10 of a DIVU.
    start_i  = 1'b1;
    funct3_i = 3'b101;
    rs1_i    = 32'd100;
    rs2_i    = 32'd7;
    saw_done = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (done_o === 1'b1) saw_done = 1'b1;
      if (c == 10) begin
        check("flush_busy_c10", 64'(busy_o), 64'd1);
        flush_i = 1'b1;
      end
      if (c == 11) begin
        flush_i = 1'b0;
        check("flush_busy_c11", 64'(busy_o), 64'd0);
      end
    end
    check("flush_no_done", 64'(saw_done), 64'd0);
    check("flush_result_kept", 64'(result_o), 64'(last_exp));

    // Start together with flush: neither a special case nor a multiply is accepted.
    for (int k = 0; k < 2; k++) begin
      start_i  = 1'b1;
      flush_i  = 1'b1;
      funct3_i = (k == 0) ? 3'b101 : 3'b000;
      rs1_i    = 32'd9;
      rs2_i    = (k == 0) ? 32'd0 : 32'd3;
      saw_done = 1'b0;
      saw_busy = 1'b0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk_i);
        start_i = 1'b0;
        flush_i = 1'b0;
        if (done_o === 1'b1) saw_done = 1'b1;
        if (busy_o === 1'b1) saw_busy = 1'b1;
      end
      check($sformatf("startflush%0d_no_done", k), 64'(saw_done), 64'd0);
      check($sformatf("startflush%0d_no_busy", k), 64'(saw_busy), 64'd0);
      check($sformatf("startflush%0d_result", k), 64'(result_o), 64'(last_exp));
    end

    // Asynchronous reset in cycle 15 of a MUL.
    start_i  = 1'b1;
    funct3_i = 3'b000;
    rs1_i    = 32'd3;
    rs2_i    = 32'd5;
    saw_done = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_i);
      start_i = 1'b0;
      if (c == 15) begin
        check("rst_pre_busy", 64'(busy_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check("rst_async_busy", 64'(busy_o), 64'd0);
        check("rst_async_done", 64'(done_o), 64'd0);
        check("rst_async_result", 64'(result_o), 64'd0);
      end else if (c == 16) begin
        rst_i = 1'b0;
      end else if (done_o === 1'b1) begin
        saw_done = 1'b1;
      end
    end
    check("rst_no_done", 64'(saw_done), 64'd0);
    check("rst_result_zero", 64'(result_o), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
